// File: rtl/mat_mult_host.sv
// mat_mult_host
// Host-side front end for the n x n matrix engine. Bus writes load the A and
// B operand arrays. A CTRL write starts a run that holds `en` high for
// RUN_CYCLES cycles. The engine result is then snapshotted, and bus reads
// return the snapshot.
//
// Ports
//   clk, rst   : clock, asynchronous active-high reset
//   write      : bus write strobe (addr/writedata)
//   read       : bus read strobe; readdata is valid the following cycle
//   addr       : 0-35 A / snapshot, 36-71 B, 72 CTRL/STATUS
//   writedata  : 36-bit element, or CTRL {.., mode, start}
//   readdata   : registered read data; STATUS = {34'b0, busy, done}
//   dataa/datab: operand arrays driven to the engine
//   en         : engine enable, high for the whole run
//   mat_mode   : 1 = matrix multiply, 0 = element-wise multiplies
//   result     : engine output, captured once per run
module mat_mult_host #(
  parameter int n          = 6,
  parameter int RUN_CYCLES = 12
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        write,
  input  logic                        read,
  input  logic [6:0]                  addr,
  input  logic [35:0]                 writedata,
  output logic [35:0]                 readdata,
  output logic [n-1:0][n-1:0][35:0]   dataa,
  output logic [n-1:0][n-1:0][35:0]   datab,
  output logic                        en,
  output logic                        mat_mode,
  input  logic [n-1:0][n-1:0][35:0]   result
);

  localparam logic [6:0] CTRL_ADDR = 7'd72;
  localparam int         B_BASE    = n * n;
  localparam logic [7:0] LAST_CNT  = 8'(RUN_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_CAPTURE, S_DONE} state_t;

  state_t                      r_state, w_next;
  logic [7:0]                  r_cnt;
  logic                        r_done;
  logic                        r_mode;
  logic [35:0]                 r_rd;
  logic [n-1:0][n-1:0][35:0]   r_a, r_b, r_snap;
  logic [35:0]                 w_rd;
  logic                        w_busy, w_ctrl_wr, w_start, w_op_wr;

  assign w_ctrl_wr = write && (addr == CTRL_ADDR);
  assign w_start   = w_ctrl_wr && writedata[0] && !w_busy;
  assign w_op_wr   = write && !w_busy;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE, S_DONE: if (w_start) w_next = S_RUN;
      S_RUN:          if (r_cnt == LAST_CNT) w_next = S_CAPTURE;
      S_CAPTURE:      w_next = S_DONE;
      default:        w_next = S_IDLE;
    endcase
  end

  // Outputs decoded straight from state, so en drops as soon as reset asserts
  always_comb begin
    en     = 1'b0;
    w_busy = 1'b0;
    case (r_state)
      S_RUN:     begin en = 1'b1; w_busy = 1'b1; end
      S_CAPTURE: w_busy = 1'b1;
      default:   ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt  <= '0;
      r_done <= 1'b0;
      r_mode <= 1'b0;
    end else begin
      if (w_start)                r_cnt <= '0;
      else if (r_state == S_RUN)  r_cnt <= r_cnt + 8'd1;

      if (w_start)                    r_done <= 1'b0;
      else if (r_state == S_CAPTURE)  r_done <= 1'b1;

      // Covers both start and mode-only CTRL writes; frozen while busy
      if (w_ctrl_wr && !w_busy) r_mode <= writedata[1];
    end
  end

  // Operand arrays: writes dropped while busy so operands hold for the run
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a <= '0;
      r_b <= '0;
    end else if (w_op_wr) begin
      for (int unsigned r = 0; r < n; r++) begin
        for (int unsigned c = 0; c < n; c++) begin
          if (addr == 7'(r * n + c))          r_a[r][c] <= writedata;
          if (addr == 7'(B_BASE + r * n + c)) r_b[r][c] <= writedata;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                        r_snap <= '0;
    else if (r_state == S_CAPTURE)  r_snap <= result;
  end

  // Read mux over pre-write state; B and unmapped addresses read as zero
  always_comb begin
    w_rd = '0;
    if (addr == CTRL_ADDR) w_rd = {34'b0, w_busy, r_done};
    for (int unsigned r = 0; r < n; r++) begin
      for (int unsigned c = 0; c < n; c++) begin
        if (addr == 7'(r * n + c)) w_rd = r_snap[r][c];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       r_rd <= '0;
    else if (read) r_rd <= w_rd;
  end

  assign readdata = r_rd;
  assign dataa    = r_a;
  assign datab    = r_b;
  assign mat_mode = r_mode;

endmodule

// File: tb/tb_mat_mult_host.sv
module tb_mat_mult_host;

  localparam int RC = 12;

  logic clk = 1'b0;
  logic rst, write, read;
  logic [6:0]  addr;
  logic [35:0] writedata, readdata;
  logic [5:0][5:0][35:0] dataa, datab, result;
  logic en, mat_mode;

  always #5 clk = ~clk;

  mat_mult_host #(.n(6), .RUN_CYCLES(RC)) dut (
    .clk(clk), .rst(rst), .write(write), .read(read), .addr(addr),
    .writedata(writedata), .readdata(readdata), .dataa(dataa), .datab(datab),
    .en(en), .mat_mode(mat_mode), .result(result)
  );

  // Behavioural engine stub driven by the DUT operand ports
  always_comb begin
    for (int r = 0; r < 6; r++) begin
      for (int c = 0; c < 6; c++) begin
        logic [35:0] acc;
        acc = '0;
        if (mat_mode) begin
          for (int k = 0; k < 6; k++) acc = acc + dataa[r][k] * datab[k][c];
        end else begin
          acc = dataa[r][c] * datab[r][c];
        end
        result[r][c] = acc;
      end
    end
  end

  int n_vec = 0;
  int n_err = 0;
  logic [35:0] exp_q[$];
  string       name_q[$];
  logic [35:0] mA[6][6], mB[6][6];
  logic [35:0] snap_m[36];
  logic        model_mode;
  int          en_cnt;
  int          mode_bad;
  logic        mode_exp;

  task automatic check(input string nm, input logic [35:0] act, input logic [35:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Read monitor: pops the expected value for every sampled read strobe
  always @(posedge clk) begin
    if (read === 1'b1 && rst !== 1'b1) begin
      #1;
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL rd_unexpected: got %0h expected none", readdata);
      end else begin
        check(name_q.pop_front(), readdata, exp_q.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    if (en === 1'b1) begin
      en_cnt++;
      if (mat_mode !== mode_exp) mode_bad++;
    end
  end

  initial begin
    #1000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  function automatic logic [35:0] model_elem(input int r, input int c);
    logic [71:0] acc;
    acc = '0;
    if (model_mode) begin
      for (int k = 0; k < 6; k++) acc = acc + 72'(mA[r][k]) * 72'(mB[k][c]);
    end else begin
      acc = 72'(mA[r][c]) * 72'(mB[r][c]);
    end
    return acc[35:0];
  endfunction

  // All bus tasks start and end at a falling edge
  task automatic bus_wr(input logic [6:0] a, input logic [35:0] d);
    write = 1'b1; addr = a; writedata = d;
    @(negedge clk);
    write = 1'b0;
  endtask

  task automatic bus_rd(input logic [6:0] a, input logic [35:0] e, input string nm);
    read = 1'b1; addr = a;
    exp_q.push_back(e);
    name_q.push_back(nm);
    @(negedge clk);
    read = 1'b0;
  endtask

  task automatic op_wr(input int a, input logic [35:0] d);
    bus_wr(7'(a), d);
    if (a < 36) mA[a / 6][a % 6] = d;
    else        mB[(a - 36) / 6][(a - 36) % 6] = d;
  endtask

  task automatic arm(input logic mode);
    model_mode = mode;
    mode_exp   = mode;
    en_cnt     = 0;
    mode_bad   = 0;
    for (int k = 0; k < 36; k++) snap_m[k] = model_elem(k / 6, k % 6);
  endtask

  task automatic run(input logic mode);
    arm(mode);
    bus_wr(7'd72, {34'b0, mode, 1'b1});
  endtask

  task automatic finish_run(input string nm);
    repeat (RC + 3) @(negedge clk);
    check({nm, "_en_count"}, 36'(en_cnt), 36'(RC));
    check({nm, "_mode_stable"}, 36'(mode_bad), 36'd0);
  endtask

  task automatic read_snap(input string nm);
    for (int k = 0; k < 36; k++) bus_rd(7'(k), snap_m[k], nm);
  endtask

  task automatic clear_model();
    for (int r = 0; r < 6; r++)
      for (int c = 0; c < 6; c++) begin
        mA[r][c] = '0;
        mB[r][c] = '0;
      end
    for (int k = 0; k < 36; k++) snap_m[k] = '0;
    model_mode = 1'b0;
    mode_exp   = 1'b0;
  endtask

  initial begin
    rst = 1'b1; write = 1'b0; read = 1'b0; addr = '0; writedata = '0;
    en_cnt = 0; mode_bad = 0;
    clear_model();
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Reset state
    check("rst_en", 36'(en), 36'd0);
    check("rst_mode", 36'(mat_mode), 36'd0);
    check("rst_readdata", readdata, 36'd0);
    check("rst_dataa", dataa[3][4], 36'd0);
    bus_rd(7'd72, 36'd0, "rst_status");
    bus_rd(7'd5,  36'd0, "rst_snap5");
    bus_rd(7'd40, 36'd0, "rst_b40");

    // Identity x index matrix, with cycle-exact status sequence
    for (int k = 0; k < 36; k++) op_wr(k, (k / 6 == k % 6) ? 36'd1 : 36'd0);
    for (int k = 0; k < 36; k++) op_wr(36 + k, 36'(k));
    check("dataa_load", dataa[2][2], mA[2][2]);
    check("datab_load", datab[4][1], mB[4][1]);
    run(1'b1);
    for (int j = 1; j <= RC + 3; j++)
      bus_rd(7'd72, (j <= RC + 1) ? 36'd2 : 36'd1, "status_seq");
    check("ident_en_count", 36'(en_cnt), 36'(RC));
    check("ident_mode_stable", 36'(mode_bad), 36'd0);
    read_snap("ident_snap");

    // Parallel mode
    for (int k = 0; k < 36; k++) op_wr(k, 36'd2);
    for (int k = 0; k < 36; k++) op_wr(36 + k, 36'((k / 6) + (k % 6)));
    run(1'b0);
    finish_run("par");
    check("par_mode", 36'(mat_mode), 36'd0);
    read_snap("par_snap");

    // Writes and a second start while busy are ignored
    run(1'b1);
    repeat (2) @(negedge clk);
    bus_wr(7'd0, 36'd7);
    bus_wr(7'd72, 36'd1);
    check("busy_wr_ignored", dataa[0][0], mA[0][0]);
    check("busy_mode_held", 36'(mat_mode), 36'd1);
    finish_run("busy");
    read_snap("busy_snap");
    op_wr(0, 36'd7);
    check("done_wr_lands", dataa[0][0], 36'd7);
    bus_rd(7'd72, 36'd1, "done_sticky");

    // Reset during the 5th enable cycle
    run(1'b0);
    repeat (4) @(negedge clk);
    #2 rst = 1'b1;
    #1 check("en_async_drop", 36'(en), 36'd0);
    @(negedge clk);
    rst = 1'b0;
    clear_model();
    check("midrst_dataa", dataa[0][0], 36'd0);
    check("midrst_mode", 36'(mat_mode), 36'd0);
    bus_rd(7'd72, 36'd0, "midrst_status");
    bus_rd(7'd0,  36'd0, "midrst_snap0");
    bus_rd(7'd20, 36'd0, "midrst_snap20");

    // Randomized operands and mode
    for (int it = 0; it < 3; it++) begin
      logic [3:0] hi;
      logic       m;
      for (int k = 0; k < 72; k++) begin
        hi = 4'($urandom);
        op_wr(k, {hi, 32'($urandom)});
      end
      m = 1'($urandom);
      run(m);
      finish_run("rand");
      read_snap("rand_snap");
      bus_rd(7'(73 + $urandom_range(54, 0)), 36'd0, "rand_unmapped");
      bus_rd(7'(36 + $urandom_range(35, 0)), 36'd0, "rand_b_read");
    end

    // Same-cycle read and start write on CTRL
    arm(1'b0);
    write = 1'b1; read = 1'b1; addr = 7'd72; writedata = 36'd1;
    exp_q.push_back(36'd1);
    name_q.push_back("rw_old_status");
    @(negedge clk);
    write = 1'b0; read = 1'b0;
    bus_rd(7'd72, 36'd2, "rw_next_busy");
    finish_run("rw");
    read_snap("rw_snap");

    @(negedge clk);
    if (exp_q.size() != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL rd_pending: got %0d outstanding expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mat_mult_host.md
# mat_mult_host

Host-side front end for the 6x6 matrix engine: it takes serial 36-bit element writes from the processor bus, builds the A and B operand arrays, runs the engine for a fixed number of enabled cycles, snapshots the 6x6 result, and serves it back through registered reads. It sits directly upstream of the matrix multiplier, driving its `dataa`, `datab`, `en` and `mat_mode` inputs, and directly downstream of it, consuming `result`.

## Interface
Parameters:
- `n`, default 6: matrix dimension. Only 6 is supported.
- `RUN_CYCLES`, default 12: number of consecutive `en` cycles per run. This is n plus the multiplier pipeline depth.

Ports:
- `clk` in 1: the single clock.
- `rst` in 1: reset, asynchronous, active-high.
- `write` in 1: bus write strobe.
- `read` in 1: bus read strobe.
- `addr` in 7: word address.
- `writedata` in 36: write data.
- `readdata` out 36: read data, registered.
- `dataa` out [5:0][5:0][35:0]: operand A to the engine.
- `datab` out [5:0][5:0][35:0]: operand B to the engine.
- `en` out 1: engine enable.
- `mat_mode` out 1: 1 selects matrix-multiply, 0 selects 36 parallel multiplies.
- `result` in [5:0][5:0][35:0]: engine output.

## Operation
Address map (element [r][c] is at base + r*6 + c):
- 0-35: A write, and snapshot read.
- 36-71: B write; reads return 0.
- 72: CTRL/STATUS.
  - Write: bit0 = start, bit1 = mode.
  - Read: {34'b0, busy, done}.
- 73-127: writes ignored, reads return 0.

States: IDLE, RUN, CAPTURE, DONE.
- IDLE or DONE, on a CTRL write with bit0=1:
  - `mat_mode` <= bit1.
  - run counter <= 0.
  - done <= 0.
  - go to RUN.
- CTRL write with bit0=0: only `mat_mode` <= bit1, and only when not busy. Otherwise ignored.
- RUN: `en`=1 every cycle. The counter increments. When the counter reaches RUN_CYCLES-1, go to CAPTURE on that edge.
- CAPTURE: `en`=0. Snapshot <= `result` (all 36 elements). Go to DONE.
- DONE: `done`=1, sticky until the next start or reset.

Rules:
- busy = state in {RUN, CAPTURE}.
- Operand writes (addr 0-71) are ignored while busy. `dataa`/`datab` are therefore stable for the whole run.
- Operand writes are accepted in IDLE and DONE and do not clear done.
- `mat_mode` never changes while busy.
- Reads of 0-35 always return the snapshot, never the live `result`.
- `write` and `read` in the same cycle are both served. The read returns the pre-write value.
- Arithmetic: no arithmetic is done here. Data passes through bit-exact. Counter is 8 bits; RUN_CYCLES must be 1..255.

## Timing
- Reset (async assert, sync deassert by the system):
  - State IDLE, counter 0.
  - `en`=0, `mat_mode`=0, `readdata`=0.
  - `dataa`, `datab` and snapshot all zero.
  - done=0.
- Operand write accepted at edge t: the element is visible on `dataa`/`datab` from t+1.
- Start write at edge t:
  - `en`=1 during cycles t+1 .. t+RUN_CYCLES.
  - CAPTURE during cycle t+RUN_CYCLES+1. The snapshot is loaded on that cycle's closing edge.
  - `done`=1 visible from t+RUN_CYCLES+2.
- Read latency: `readdata` is valid the cycle after `read` is sampled. It holds until the next read.
- Start write while busy: ignored, no restart.
- Reset mid-run: immediate return to IDLE. `en` drops asynchronously. Snapshot is cleared.

## Test plan
- Reset, then read addr 72, 5 and 40 → readdata 0 each; `en`=0, `mat_mode`=0.
- Write A = identity, B[r][c] = r*6+c, then CTRL=3 (matrix mode) → `en` high for exactly 12 cycles, `mat_mode`=1 throughout, STATUS reads 2 while running and 1 after; reads of 0-35 return r*6+c.
- CTRL=1 (parallel mode) with A[r][c]=2 and B[r][c]=r+c → snapshot[r][c]=2(r+c); `mat_mode`=0 during the run.
- Write A[0][0]=7 while busy, and issue a second start while busy → `dataa[0][0]` unchanged and `en` count still 12; after DONE, the same write lands and done stays 1.
- Assert `rst` at the 5th `en` cycle → `en` falls without waiting for a clock edge; STATUS reads 0; the snapshot reads 0.
- Same-cycle read and write to addr 72 with start → read returns the old status (done=1); the next read returns busy (2).
